wav_dfi_phy_hs_resp: RTL and testbench
======================================

WAV_DFI_PHY_HS_RESP -- requirements
Module: wav_dfi_phy_hs_resp

Interface
REQ-001 The module SHALL use one clock and a synchronous active-high reset: clock, reset, with reset sampled only on posedge clock.
REQ-002 The ports SHALL be as follows, one per line: name  direction  width  meaning.
  clock  in  1  DFI clock; all state updates on posedge.
  reset  in  1  synchronous active-high reset.
  lp_ctrl_req  in  1  MC low-power control request.
  lp_ctrl_wakeup  in  6  MC control wakeup code.
  lp_ctrl_ack  out  1  PHY control low-power acknowledge.
  lp_data_req  in  1  MC low-power data request.
  lp_data_wakeup  in  6  MC data wakeup code.
  lp_data_ack  out  1  PHY data low-power acknowledge.
  ctrlupd_req  in  1  MC-initiated update request.
  ctrlupd_ack  out  1  PHY update acknowledge.
  phyupd_req  out  1  PHY-initiated update request.
  phyupd_type  out  2  PHY update type.
  phyupd_ack  in  1  MC acknowledge of phyupd_req.
  cfg_lp_en  in  1  1 = acknowledge low-power requests.
  cfg_lp_ack_dly  in  4  extra cycles before a low-power ack.
  cfg_ctrlupd_en  in  1  1 = acknowledge ctrlupd_req.
  cfg_phyupd_hold  in  4  cycles phyupd_req is held after ack.
  phyupd_trig  in  1  single-cycle pulse that launches a PHY update.
  phyupd_trig_type  in  2  type captured with phyupd_trig.
  phyupd_busy  out  1  PHY-update FSM not in IDLE.
  lp_ctrl_wakeup_q  out  6  wakeup code latched at lp_ctrl_req rise.
  lp_data_wakeup_q  out  6  wakeup code latched at lp_data_req rise.
  err_phyupd_timeout  out  1  sticky; no phyupd_ack within TPHYUPD_RESP.
  err_clr  in  1  clears err_phyupd_timeout.
REQ-003 Parameter TPHYUPD_RESP SHALL default to 32 cycles; its counter SHALL be clog2(TPHYUPD_RESP+1) bits wide.

Function
REQ-004 Two identical low-power FSMs SHALL exist, one for the ctrl channel and one for the data channel. Each has states IDLE, WAIT and ACK, and a 4-bit counter.
REQ-005 IDLE -> WAIT SHALL occur when req=1 and cfg_lp_en=1. On that transition, the counter is cleared and the wakeup code is latched into *_wakeup_q.
REQ-006 WAIT -> ACK SHALL occur when counter==cfg_lp_ack_dly; otherwise the counter increments. As a result, ack is first high at edge N+1+cfg_lp_ack_dly when req is first sampled high at edge N.
REQ-007 WAIT -> IDLE SHALL occur whenever req=0. In that case no ack is issued (aborted request).
REQ-008 In ACK, ack SHALL be 1 (registered). ACK -> IDLE SHALL occur when req=0, so ack falls exactly one cycle after req is sampled low.
REQ-009 With cfg_lp_en=0, the FSM SHALL remain in IDLE and never assert ack. Changing cfg_lp_en while in WAIT or ACK SHALL have no effect until the FSM returns to IDLE.
REQ-010 ctrlupd_ack SHALL equal ack_q AND ctrlupd_req. ack_q sets on the cycle after ctrlupd_req=1 with cfg_ctrlupd_en=1 and phyupd_busy=0, and clears when ctrlupd_req=0. ctrlupd_ack is therefore never high while ctrlupd_req is low.
REQ-011 The PHY-update FSM SHALL have states IDLE, REQ, HOLD and RELEASE, with one shared counter.
REQ-012 IDLE -> REQ SHALL occur on phyupd_trig=1 when ack_q=0 and ctrlupd_req=0. On that transition, phyupd_type is latched from phyupd_trig_type and the counter is cleared.
REQ-013 A phyupd_trig that arrives while not in IDLE, or while ctrlupd is active, SHALL set a single pending flag. The pending trigger launches on the first eligible IDLE cycle, using the type captured at the first pending trigger; further triggers while pending are dropped.
REQ-014 In REQ, phyupd_req SHALL be 1.
  - On phyupd_ack=1: go to HOLD and clear the counter.
  - Otherwise, if counter==TPHYUPD_RESP: set err_phyupd_timeout and go to RELEASE.
  - Otherwise: increment the counter.
REQ-015 In HOLD, phyupd_req SHALL be 1. HOLD -> RELEASE SHALL occur when counter==cfg_phyupd_hold.
REQ-016 In RELEASE, phyupd_req SHALL be 0. RELEASE -> IDLE SHALL occur when phyupd_ack=0.
REQ-017 phyupd_req SHALL be registered and never 1 while ctrlupd_ack=1.
REQ-018 err_phyupd_timeout SHALL be sticky until err_clr=1. If a set and err_clr occur in the same cycle, the set wins.
REQ-019 phyupd_busy SHALL be 1 in REQ, HOLD and RELEASE.

Reset
REQ-020 Under reset=1, all FSMs SHALL go to IDLE and all counters, ack_q and the pending flag SHALL clear. Every output SHALL be 0 at the first posedge with reset=1, including *_wakeup_q, phyupd_type and err_phyupd_timeout.
REQ-021 Reset asserted mid-handshake SHALL drop all acks and phyupd_req on the next edge without waiting for the protocol; after reset deasserts, requests are processed only from a fresh rise.

Verification
REQ-022 Set cfg_lp_ack_dly=3, drive lp_ctrl_req=1 at edge 10 with wakeup=0x15, then req=0 at edge 20 -> lp_ctrl_ack rises at edge 14, falls at edge 21, and lp_ctrl_wakeup_q=0x15.
REQ-023 Set cfg_lp_ack_dly=5, pulse lp_data_req for 3 cycles -> lp_data_ack stays 0 and the FSM returns to IDLE.
REQ-024 Drive ctrlupd_req=1 for 6 cycles -> ctrlupd_ack is high for 5 cycles and is 0 in the same cycle req drops. With cfg_ctrlupd_en=0 -> ack never rises.
REQ-025 Pulse phyupd_trig with type=2 and cfg_phyupd_hold=4, with MC ack after 3 cycles -> phyupd_type=2, phyupd_req held 4 cycles after ack then low, and busy clears after ack falls.
REQ-026 Pulse phyupd_trig with phyupd_ack tied 0 -> phyupd_req drops after 33 REQ cycles, err_phyupd_timeout=1, and err_clr restores 0.
REQ-027 Pulse phyupd_trig during an active ctrlupd -> phyupd_req is deferred until ctrlupd_req falls, then asserts.

Source files
------------

// File: rtl/wav_dfi_phy_hs_resp.sv
// DFI PHY-side handshake responder: low-power ctrl/data acknowledge, MC-initiated update
// acknowledge, and PHY-initiated update request with response timeout.
module wav_dfi_phy_hs_resp #(
  parameter int unsigned TPHYUPD_RESP = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       lp_ctrl_req,
  input  logic [5:0] lp_ctrl_wakeup,
  output logic       lp_ctrl_ack,
  input  logic       lp_data_req,
  input  logic [5:0] lp_data_wakeup,
  output logic       lp_data_ack,
  input  logic       ctrlupd_req,
  output logic       ctrlupd_ack,
  output logic       phyupd_req,
  output logic [1:0] phyupd_type,
  input  logic       phyupd_ack,
  input  logic       cfg_lp_en,
  input  logic [3:0] cfg_lp_ack_dly,
  input  logic       cfg_ctrlupd_en,
  input  logic [3:0] cfg_phyupd_hold,
  input  logic       phyupd_trig,
  input  logic [1:0] phyupd_trig_type,
  output logic       phyupd_busy,
  output logic [5:0] lp_ctrl_wakeup_q,
  output logic [5:0] lp_data_wakeup_q,
  output logic       err_phyupd_timeout,
  input  logic       err_clr
);

  localparam int unsigned CntW = $clog2(TPHYUPD_RESP + 1);
  localparam logic [CntW-1:0] RespMax = CntW'(TPHYUPD_RESP);

  localparam logic [1:0] LpIdle = 2'd0;
  localparam logic [1:0] LpWait = 2'd1;
  localparam logic [1:0] LpAck  = 2'd2;

  localparam logic [1:0] PuIdle = 2'd0;
  localparam logic [1:0] PuReq  = 2'd1;
  localparam logic [1:0] PuHold = 2'd2;
  localparam logic [1:0] PuRel  = 2'd3;

  // ---------------------------------------------------------------------------------------------
  // Low-power channels: index 0 = ctrl, index 1 = data
  // ---------------------------------------------------------------------------------------------
  logic [1:0] lp_req;
  logic [5:0] lp_wakeup [2];
  logic [1:0] lp_st_q   [2];
  logic [1:0] lp_st_d   [2];
  logic [3:0] lp_cnt_q  [2];
  logic [3:0] lp_cnt_d  [2];
  logic [5:0] lp_wake_q [2];
  logic [5:0] lp_wake_d [2];
  // Blocks a request that was already high when reset released until it is seen low.
  logic [1:0] lp_blk_q, lp_blk_d;

  assign lp_req       = {lp_data_req, lp_ctrl_req};
  assign lp_wakeup[0] = lp_ctrl_wakeup;
  assign lp_wakeup[1] = lp_data_wakeup;

  always_comb begin
    lp_blk_d = lp_blk_q & lp_req;
    for (int c = 0; c < 2; c++) begin
      lp_st_d[c]   = lp_st_q[c];
      lp_cnt_d[c]  = lp_cnt_q[c];
      lp_wake_d[c] = lp_wake_q[c];
      case (lp_st_q[c])
        LpIdle: begin
          if (lp_req[c] && cfg_lp_en && !lp_blk_q[c]) begin
            lp_st_d[c]   = LpWait;
            lp_cnt_d[c]  = '0;
            lp_wake_d[c] = lp_wakeup[c];
          end
        end
        LpWait: begin
          if (!lp_req[c]) begin
            lp_st_d[c] = LpIdle;
          end else if (lp_cnt_q[c] == cfg_lp_ack_dly) begin
            lp_st_d[c] = LpAck;
          end else begin
            lp_cnt_d[c] = lp_cnt_q[c] + 4'd1;
          end
        end
        LpAck: begin
          if (!lp_req[c]) begin
            lp_st_d[c] = LpIdle;
          end
        end
        default: lp_st_d[c] = LpIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        lp_st_q[c]   <= LpIdle;
        lp_cnt_q[c]  <= '0;
        lp_wake_q[c] <= '0;
      end
      lp_blk_q <= lp_req;
    end else begin
      for (int c = 0; c < 2; c++) begin
        lp_st_q[c]   <= lp_st_d[c];
        lp_cnt_q[c]  <= lp_cnt_d[c];
        lp_wake_q[c] <= lp_wake_d[c];
      end
      lp_blk_q <= lp_blk_d;
    end
  end

  assign lp_ctrl_ack      = (lp_st_q[0] == LpAck);
  assign lp_data_ack      = (lp_st_q[1] == LpAck);
  assign lp_ctrl_wakeup_q = lp_wake_q[0];
  assign lp_data_wakeup_q = lp_wake_q[1];

  // ---------------------------------------------------------------------------------------------
  // MC-initiated update acknowledge
  // ---------------------------------------------------------------------------------------------
  logic cu_ack_q, cu_ack_d;
  logic cu_blk_q, cu_blk_d;

  always_comb begin
    cu_blk_d = cu_blk_q & ctrlupd_req;
    cu_ack_d = ctrlupd_req &&
               (cu_ack_q || (cfg_ctrlupd_en && !phyupd_busy && !cu_blk_q));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cu_ack_q <= 1'b0;
      cu_blk_q <= ctrlupd_req;
    end else begin
      cu_ack_q <= cu_ack_d;
      cu_blk_q <= cu_blk_d;
    end
  end

  // Gating with the live request drops the ack in the same cycle the request falls.
  assign ctrlupd_ack = cu_ack_q & ctrlupd_req;

  // ---------------------------------------------------------------------------------------------
  // PHY-initiated update
  // ---------------------------------------------------------------------------------------------
  logic [1:0]      pu_st_q, pu_st_d;
  logic [CntW-1:0] pu_cnt_q, pu_cnt_d;
  logic [1:0]      pu_type_q, pu_type_d;
  logic            pu_req_q, pu_req_d;
  logic            pend_q, pend_d;
  logic [1:0]      pend_type_q, pend_type_d;
  logic            err_q, err_d;
  logic            err_set;
  logic            pu_eligible;
  logic            pu_launch;

  assign pu_eligible = (pu_st_q == PuIdle) && !cu_ack_q && !ctrlupd_req;
  assign pu_launch   = pu_eligible && (phyupd_trig || pend_q);

  always_comb begin
    pu_st_d     = pu_st_q;
    pu_cnt_d    = pu_cnt_q;
    pu_type_d   = pu_type_q;
    pend_d      = pend_q;
    pend_type_d = pend_type_q;
    err_set     = 1'b0;

    // A trigger that cannot launch now is remembered once; later ones are dropped.
    if (pu_launch) begin
      pend_d = 1'b0;
    end else if (phyupd_trig && !pend_q) begin
      pend_d      = 1'b1;
      pend_type_d = phyupd_trig_type;
    end

    case (pu_st_q)
      PuIdle: begin
        if (pu_launch) begin
          pu_st_d   = PuReq;
          pu_cnt_d  = '0;
          pu_type_d = pend_q ? pend_type_q : phyupd_trig_type;
        end
      end
      PuReq: begin
        if (phyupd_ack) begin
          pu_st_d  = PuHold;
          pu_cnt_d = '0;
        end else if (pu_cnt_q == RespMax) begin
          err_set = 1'b1;
          pu_st_d = PuRel;
        end else begin
          pu_cnt_d = pu_cnt_q + CntW'(1);
        end
      end
      PuHold: begin
        if (pu_cnt_q == CntW'(cfg_phyupd_hold)) begin
          pu_st_d = PuRel;
        end else begin
          pu_cnt_d = pu_cnt_q + CntW'(1);
        end
      end
      PuRel: begin
        if (!phyupd_ack) begin
          pu_st_d = PuIdle;
        end
      end
      default: pu_st_d = PuIdle;
    endcase

    pu_req_d = (pu_st_d == PuReq) || (pu_st_d == PuHold);
    err_d    = err_set || (err_q && !err_clr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pu_st_q     <= PuIdle;
      pu_cnt_q    <= '0;
      pu_type_q   <= '0;
      pu_req_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_type_q <= '0;
      err_q       <= 1'b0;
    end else begin
      pu_st_q     <= pu_st_d;
      pu_cnt_q    <= pu_cnt_d;
      pu_type_q   <= pu_type_d;
      pu_req_q    <= pu_req_d;
      pend_q      <= pend_d;
      pend_type_q <= pend_type_d;
      err_q       <= err_d;
    end
  end

  assign phyupd_req         = pu_req_q;
  assign phyupd_type        = pu_type_q;
  assign phyupd_busy        = (pu_st_q != PuIdle);
  assign err_phyupd_timeout = err_q;

endmodule

// File: tb/tb_wav_dfi_phy_hs_resp.sv
// Scoreboard bench for wav_dfi_phy_hs_resp: expected values queued per driven cycle.
module tb_wav_dfi_phy_hs_resp;

  logic       clock = 1'b0;
  logic       reset;
  logic       lp_ctrl_req;
  logic [5:0] lp_ctrl_wakeup;
  logic       lp_ctrl_ack;
  logic       lp_data_req;
  logic [5:0] lp_data_wakeup;
  logic       lp_data_ack;
  logic       ctrlupd_req;
  logic       ctrlupd_ack;
  logic       phyupd_req;
  logic [1:0] phyupd_type;
  logic       phyupd_ack;
  logic       cfg_lp_en;
  logic [3:0] cfg_lp_ack_dly;
  logic       cfg_ctrlupd_en;
  logic [3:0] cfg_phyupd_hold;
  logic       phyupd_trig;
  logic [1:0] phyupd_trig_type;
  logic       phyupd_busy;
  logic [5:0] lp_ctrl_wakeup_q;
  logic [5:0] lp_data_wakeup_q;
  logic       err_phyupd_timeout;
  logic       err_clr;

  int vecs = 0;
  int errs = 0;
  logic [7:0] exp_q[$];

  wav_dfi_phy_hs_resp dut (
    .clock              (clock),
    .reset              (reset),
    .lp_ctrl_req        (lp_ctrl_req),
    .lp_ctrl_wakeup     (lp_ctrl_wakeup),
    .lp_ctrl_ack        (lp_ctrl_ack),
    .lp_data_req        (lp_data_req),
    .lp_data_wakeup     (lp_data_wakeup),
    .lp_data_ack        (lp_data_ack),
    .ctrlupd_req        (ctrlupd_req),
    .ctrlupd_ack        (ctrlupd_ack),
    .phyupd_req         (phyupd_req),
    .phyupd_type        (phyupd_type),
    .phyupd_ack         (phyupd_ack),
    .cfg_lp_en          (cfg_lp_en),
    .cfg_lp_ack_dly     (cfg_lp_ack_dly),
    .cfg_ctrlupd_en     (cfg_ctrlupd_en),
    .cfg_phyupd_hold    (cfg_phyupd_hold),
    .phyupd_trig        (phyupd_trig),
    .phyupd_trig_type   (phyupd_trig_type),
    .phyupd_busy        (phyupd_busy),
    .lp_ctrl_wakeup_q   (lp_ctrl_wakeup_q),
    .lp_data_wakeup_q   (lp_data_wakeup_q),
    .err_phyupd_timeout (err_phyupd_timeout),
    .err_clr            (err_clr)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    vecs++;
    if ({lp_ctrl_ack, lp_data_ack, ctrlupd_ack, phyupd_req, phyupd_busy, err_phyupd_timeout}
        !== 6'b0) begin
      errs++;
      $display("FAIL reset_flags got %b exp 000000", {lp_ctrl_ack, lp_data_ack, ctrlupd_ack,
               phyupd_req, phyupd_busy, err_phyupd_timeout});
    end
    vecs++;
    if ({lp_ctrl_wakeup_q, lp_data_wakeup_q, phyupd_type} !== 14'd0) begin
      errs++;
      $display("FAIL reset_regs got %h/%h/%h exp 0/0/0", lp_ctrl_wakeup_q, lp_data_wakeup_q,
               phyupd_type);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_lp_ctrl();
    logic [7:0] e;
    cfg_lp_en      = 1'b1;
    cfg_lp_ack_dly = 4'd3;
    // k=0 is the first edge sampling req high; req is sampled low first at k=11.
    for (int k = 0; k < 14; k++) begin
      lp_ctrl_req    = (k <= 10);
      lp_ctrl_wakeup = (k == 0) ? 6'h15 : 6'h2a;
      exp_q.push_back({6'd0, 1'b0, (k >= 4 && k <= 10)});
      step();
      e = exp_q.pop_front();
      vecs++;
      if ({lp_data_ack, lp_ctrl_ack} !== e[1:0]) begin
        errs++;
        $display("FAIL lp_ctrl_ack k=%0d got data/ctrl %b%b exp %b", k, lp_data_ack, lp_ctrl_ack,
                 e[1:0]);
      end
    end
    vecs++;
    if (lp_ctrl_wakeup_q !== 6'h15) begin
      errs++;
      $display("FAIL lp_ctrl_wakeup_q got %h exp 15", lp_ctrl_wakeup_q);
    end
  endtask

  task automatic test_lp_abort();
    logic [7:0] e;
    cfg_lp_ack_dly = 4'd5;
    for (int k = 0; k < 10; k++) begin
      lp_data_req    = (k < 3);
      lp_data_wakeup = 6'h0a;
      exp_q.push_back(8'd0);
      step();
      e = exp_q.pop_front();
      vecs++;
      if (lp_data_ack !== e[0]) begin
        errs++;
        $display("FAIL lp_data_abort k=%0d got %b exp %b", k, lp_data_ack, e[0]);
      end
    end
    vecs++;
    if (lp_data_wakeup_q !== 6'h0a) begin
      errs++;
      $display("FAIL lp_data_wakeup_q got %h exp 0a", lp_data_wakeup_q);
    end
    // A zero-delay request acks one edge after it is sampled only if the FSM is back in IDLE.
    cfg_lp_ack_dly = 4'd0;
    for (int k = 0; k < 4; k++) begin
      lp_data_req = 1'b1;
      exp_q.push_back({7'd0, (k >= 1)});
      step();
      e = exp_q.pop_front();
      vecs++;
      if (lp_data_ack !== e[0]) begin
        errs++;
        $display("FAIL lp_data_after_abort k=%0d got %b exp %b", k, lp_data_ack, e[0]);
      end
    end
    lp_data_req = 1'b0;
    step();
  endtask

  task automatic test_lp_enable();
    logic [7:0] e;
    cfg_lp_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      lp_ctrl_req = 1'b1;
      exp_q.push_back(8'd0);
      step();
      e = exp_q.pop_front();
      vecs++;
      if (lp_ctrl_ack !== e[0]) begin
        errs++;
        $display("FAIL lp_disabled k=%0d got %b exp %b", k, lp_ctrl_ack, e[0]);
      end
    end
    lp_ctrl_req = 1'b0;
    step();
    // Dropping the enable after entering WAIT must not stop the handshake.
    cfg_lp_ack_dly = 4'd2;
    for (int k = 0; k < 8; k++) begin
      lp_ctrl_req = (k <= 5);
      cfg_lp_en   = (k == 0);
      exp_q.push_back({7'd0, (k >= 3 && k <= 5)});
      step();
      e = exp_q.pop_front();
      vecs++;
      if (lp_ctrl_ack !== e[0]) begin
        errs++;
        $display("FAIL lp_enable_change k=%0d got %b exp %b", k, lp_ctrl_ack, e[0]);
      end
    end
    cfg_lp_en = 1'b1;
  endtask

  task automatic test_ctrlupd();
    logic [7:0] e;
    for (int pass = 0; pass < 2; pass++) begin
      cfg_ctrlupd_en = (pass == 0);
      for (int k = 0; k < 8; k++) begin
        ctrlupd_req = (k < 6);
        exp_q.push_back({7'd0, (pass == 0 && k >= 1 && k <= 5)});
        #2;
        e = exp_q.pop_front();
        vecs++;
        if (ctrlupd_ack !== e[0]) begin
          errs++;
          $display("FAIL ctrlupd_ack en=%0d k=%0d got %b exp %b", 1 - pass, k, ctrlupd_ack,
                   e[0]);
        end
        step();
      end
    end
    cfg_ctrlupd_en = 1'b1;
  endtask

  task automatic test_phyupd();
    logic [7:0] e;
    cfg_phyupd_hold = 4'd4;
    for (int k = 0; k < 12; k++) begin
      phyupd_trig      = (k == 0);
      phyupd_trig_type = (k == 0) ? 2'd2 : 2'd1;
      phyupd_ack       = (k >= 3 && k <= 8);
      exp_q.push_back({6'd0, (k <= 8), (k <= 7)});
      step();
      e = exp_q.pop_front();
      vecs++;
      if ({phyupd_busy, phyupd_req} !== e[1:0]) begin
        errs++;
        $display("FAIL phyupd_hold k=%0d got busy/req %b%b exp %b", k, phyupd_busy, phyupd_req,
                 e[1:0]);
      end
    end
    phyupd_trig = 1'b0;
    vecs++;
    if (phyupd_type !== 2'd2) begin
      errs++;
      $display("FAIL phyupd_type got %0d exp 2", phyupd_type);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] e;
    phyupd_ack = 1'b0;
    // Pass 1 holds err_clr throughout: the set at the timeout edge must still win.
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 36; k++) begin
        phyupd_trig      = (k == 0);
        phyupd_trig_type = 2'd1;
        err_clr          = (pass == 1);
        exp_q.push_back({5'd0, (pass == 0) ? (k >= 33) : (k == 33), (k <= 33), (k <= 32)});
        step();
        e = exp_q.pop_front();
        vecs++;
        if ({err_phyupd_timeout, phyupd_busy, phyupd_req} !== e[2:0]) begin
          errs++;
          $display("FAIL timeout pass=%0d k=%0d got err/busy/req %b%b%b exp %b", pass, k,
                   err_phyupd_timeout, phyupd_busy, phyupd_req, e[2:0]);
        end
      end
      phyupd_trig = 1'b0;
      err_clr     = 1'b0;
      if (pass == 0) begin
        step();
        step();
        vecs++;
        if (err_phyupd_timeout !== 1'b1) begin
          errs++;
          $display("FAIL err_sticky got %b exp 1", err_phyupd_timeout);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        vecs++;
        if (err_phyupd_timeout !== 1'b0) begin
          errs++;
          $display("FAIL err_clr got %b exp 0", err_phyupd_timeout);
        end
      end
    end
  endtask

  task automatic test_deferred();
    logic [7:0] e;
    bit         done;
    cfg_ctrlupd_en  = 1'b1;
    cfg_phyupd_hold = 4'd0;
    phyupd_ack      = 1'b0;
    for (int k = 0; k < 11; k++) begin
      ctrlupd_req      = (k <= 7);
      phyupd_trig      = (k == 3) || (k == 5);
      phyupd_trig_type = (k == 3) ? 2'd3 : 2'd1;
      exp_q.push_back({6'd0, (k <= 7), (k >= 9)});
      step();
      e = exp_q.pop_front();
      vecs++;
      if ({ctrlupd_ack, phyupd_req} !== e[1:0]) begin
        errs++;
        $display("FAIL deferred k=%0d got cuack/req %b%b exp %b", k, ctrlupd_ack, phyupd_req,
                 e[1:0]);
      end
    end
    phyupd_trig = 1'b0;
    vecs++;
    if (phyupd_type !== 2'd3) begin
      errs++;
      $display("FAIL deferred_type got %0d exp 3", phyupd_type);
    end
    phyupd_ack = 1'b1;
    done       = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (!phyupd_req) phyupd_ack = 1'b0;
      if (!phyupd_busy) done = 1'b1;
    end
    phyupd_ack = 1'b0;
    vecs++;
    if (phyupd_busy !== 1'b0) begin
      errs++;
      $display("FAIL deferred_complete busy got %b exp 0 within 20 cycles", phyupd_busy);
    end
    // The second trigger arrived while one was pending and must have been dropped.
    for (int i = 0; i < 5; i++) step();
    vecs++;
    if (phyupd_busy !== 1'b0) begin
      errs++;
      $display("FAIL dropped_trig busy got %b exp 0", phyupd_busy);
    end
  endtask

  task automatic test_reset_mid();
    cfg_lp_ack_dly = 4'd0;
    lp_ctrl_req    = 1'b1;
    lp_ctrl_wakeup = 6'h33;
    step();
    step();
    phyupd_trig      = 1'b1;
    phyupd_trig_type = 2'd2;
    step();
    phyupd_trig = 1'b0;
    vecs++;
    if ({lp_ctrl_ack, phyupd_req} !== 2'b11) begin
      errs++;
      $display("FAIL mid_setup got ack/req %b%b exp 11", lp_ctrl_ack, phyupd_req);
    end
    reset = 1'b1;
    step();
    vecs++;
    if ({lp_ctrl_ack, lp_data_ack, ctrlupd_ack, phyupd_req, phyupd_busy, err_phyupd_timeout,
         lp_ctrl_wakeup_q, lp_data_wakeup_q, phyupd_type} !== 20'd0) begin
      errs++;
      $display("FAIL mid_reset got ack %b req %b busy %b wk %h type %0d exp all 0", lp_ctrl_ack,
               phyupd_req, phyupd_busy, lp_ctrl_wakeup_q, phyupd_type);
    end
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      vecs++;
      if ({lp_ctrl_ack, phyupd_req} !== 2'b00) begin
        errs++;
        $display("FAIL post_reset_hold k=%0d got ack/req %b%b exp 00", k, lp_ctrl_ack,
                 phyupd_req);
      end
    end
    lp_ctrl_req = 1'b0;
    step();
    lp_ctrl_req = 1'b1;
    step();
    step();
    vecs++;
    if (lp_ctrl_ack !== 1'b1) begin
      errs++;
      $display("FAIL fresh_rise got %b exp 1", lp_ctrl_ack);
    end
    lp_ctrl_req = 1'b0;
    step();
  endtask

  initial begin
    reset            = 1'b1;
    lp_ctrl_req      = 1'b0;
    lp_ctrl_wakeup   = 6'd0;
    lp_data_req      = 1'b0;
    lp_data_wakeup   = 6'd0;
    ctrlupd_req      = 1'b0;
    phyupd_ack       = 1'b0;
    cfg_lp_en        = 1'b1;
    cfg_lp_ack_dly   = 4'd0;
    cfg_ctrlupd_en   = 1'b1;
    cfg_phyupd_hold  = 4'd0;
    phyupd_trig      = 1'b0;
    phyupd_trig_type = 2'd0;
    err_clr          = 1'b0;
    test_reset();
    test_lp_ctrl();
    test_lp_abort();
    test_lp_enable();
    test_ctrlupd();
    test_phyupd();
    test_timeout();
    test_deferred();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
